uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between NREQ byte-stream requesters (command echo, status, debug, ...).

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between NREQ requesters, the arbiter and the UART TX byte input.
// master = requester/UART side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   tx_valid;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin UART TX sharer with per-message grant locking and an idle watchdog.
// Define UART_ARB_PRIO0_EN to give requester 0 absolute priority at each IDLE decision.
module uart_tx_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int DATA_W  = 8,
  parameter  int TIMEOUT = 255,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  uart_tx_arbiter_if.slave      bus,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  abort
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     idle_q, idle_d;
  logic [GW:0]       pick;
  logic              tx_valid;
  logic [NREQ-1:0]   req_ready;
  logic              timeout_hit;

  // Returns {found, index}: first valid requester after p, wrapping modulo NREQ.
  function automatic logic [GW:0] rr_pick(input logic [GW-1:0] p, input logic [NREQ-1:0] v);
    logic [GW:0]   r;
    logic [GW-1:0] c;
    r = {1'b0, p};
    for (int k = NREQ; k >= 1; k--) begin
      c = GW'((int'(p) + k) % NREQ);
      if (v[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  assign pick        = rr_pick(ptr_q, bus.req_valid);
  assign timeout_hit = (TIMEOUT > 0) && (idle_q == CW'(TIMEOUT));

`ifdef UART_ARB_PRIO0_EN
  logic prio_q, prio_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    idle_d    = '0;
    abort     = 1'b0;
    tx_valid  = 1'b0;
    req_ready = '0;
`ifdef UART_ARB_PRIO0_EN
    prio_d    = prio_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_ARB_PRIO0_EN
        if (enable && bus.req_valid[0]) begin
          grant_d = '0;
          prio_d  = 1'b1;
          state_d = XFER;
        end else if (enable && pick[GW]) begin
          grant_d = pick[GW-1:0];
          prio_d  = 1'b0;
          state_d = XFER;
        end
`else
        if (enable && pick[GW]) begin
          grant_d = pick[GW-1:0];
          state_d = XFER;
        end
`endif
      end
      XFER: begin
        // The watchdog outranks a valid that shows up on the expiry cycle.
        if (timeout_hit) begin
          abort   = 1'b1;
          ptr_d   = grant_q;
          state_d = IDLE;
        end else begin
          tx_valid           = bus.req_valid[grant_q];
          req_ready[grant_q] = bus.tx_ready;
          if (tx_valid && bus.tx_ready && bus.req_last[grant_q]) begin
`ifdef UART_ARB_PRIO0_EN
            if (!prio_q) ptr_d = grant_q;
`else
            ptr_d = grant_q;
`endif
            state_d = IDLE;
          end
          if (!tx_valid && (TIMEOUT > 0)) idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= GW'(NREQ - 1);
      grant_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idle_q  <= idle_d;
    end
  end

`ifdef UART_ARB_PRIO0_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end
`endif

  assign bus.tx_valid  = tx_valid;
  assign bus.req_ready = req_ready;
  assign bus.tx_data   = bus.req_data[grant_q*DATA_W +: DATA_W];
  assign grant_id      = grant_q;
  assign busy          = (state_q == XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table for round-robin order plus hand sequences
// for locking, watchdog abort, enable gating and asynchronous reset.
module tb_uart_tx_arbiter;

  localparam logic [31:0] DATA = 32'h44_22_11_33;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [1:0] grant_id;
  logic       busy;
  logic       abort;
  int         checks = 0;
  int         failures = 0;
  int         bi;

  uart_tx_arbiter_if #(.NREQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       en;
    logic       rdy;
    logic       e_busy;
    logic [1:0] e_gid;
    logic       e_txv;
    logic [7:0] e_dat;
    logic [3:0] e_rdy;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [1:0] g);
    case (g)
      2'd0:    return 8'h33;
      2'd1:    return 8'h11;
      2'd2:    return 8'h22;
      default: return 8'h44;
    endcase
  endfunction

  task automatic wait_busy(input string nm);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_granted"}, 32'(got), 32'd1);
  endtask

  task automatic round(input logic [3:0] vm, input logic [1:0] eg, input string nm);
    @(negedge clk);
    bus.req_data  = DATA;
    bus.req_last  = 4'hF;
    bus.tx_ready  = 1'b1;
    bus.req_valid = vm;
    wait_busy(nm);
    chk({nm, "_gid"}, 32'(grant_id), 32'(eg));
    chk({nm, "_data"}, 32'(bus.tx_data), 32'(byte_of(eg)));
    @(negedge clk);
    bus.req_valid = 4'b0;
    #1;
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    //          vld     en    rdy   busy  gid    txv   dat     ready
    tbl[0]  = '{4'b0110, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
    tbl[1]  = '{4'b0110, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h11, 4'b0010};
    tbl[2]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000};
    tbl[3]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 8'h22, 4'b0100};
    tbl[4]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00, 4'b0000};
    tbl[5]  = '{4'b1001, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 8'h44, 4'b0000};
    tbl[6]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 8'h44, 4'b1000};
    tbl[7]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 4'b0000};
    tbl[8]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h33, 4'b0001};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
    tbl[10] = '{4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
    tbl[11] = '{4'b0010, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
    tbl[12] = '{4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h11, 4'b0010};
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000};

    resetn        = 1'b0;
    enable        = 1'b0;
    bus.req_valid = 4'b0;
    bus.req_data  = DATA;
    bus.req_last  = 4'hF;
    bus.tx_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txv", 32'(bus.tx_valid), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.req_valid = tbl[i].vld;
      enable        = tbl[i].en;
      bus.tx_ready  = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_gid", i), 32'(grant_id), 32'(tbl[i].e_gid));
      chk($sformatf("row%0d_txv", i), 32'(bus.tx_valid), 32'(tbl[i].e_txv));
      chk($sformatf("row%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      if (tbl[i].e_txv)
        chk($sformatf("row%0d_data", i), 32'(bus.tx_data), 32'(tbl[i].e_dat));
    end

    // Lock: req0 streams three bytes with req3 waiting; req3 must not be served mid-message.
    round(4'b1000, 2'd3, "pre_lock");
    @(negedge clk);
    bus.req_data  = {8'h77, 8'h22, 8'h11, 8'hA0};
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b1000;
    bus.tx_ready  = 1'b0;
    bi = 0;
    for (int c = 0; c < 40 && bi < 3; c++) begin
      @(negedge clk);
      bus.req_data[7:0] = 8'hA0 + 8'(bi);
      bus.req_last[0]   = (bi == 2);
      bus.tx_ready      = c[0];
      #1;
      if (busy) begin
        chk("lock_gid", 32'(grant_id), 32'd0);
        chk("lock_rdy3", 32'(bus.req_ready[3]), 32'd0);
      end
      if (busy && bus.req_ready[0]) begin
        chk("lock_byte", 32'(bus.tx_data), 32'(8'hA0 + 8'(bi)));
        bi++;
      end
    end
    chk("lock_done", 32'(bi), 32'd3);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    bus.tx_ready  = 1'b1;
    #1;
    chk("lock_arb_idle", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("lock_next_busy", 32'(busy), 32'd1);
    chk("lock_next_gid", 32'(grant_id), 32'd3);
    chk("lock_next_data", 32'(bus.tx_data), 32'h77);
    chk("lock_next_ready", 32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    bus.req_valid = 4'b0;

    // Watchdog: req1 sends one byte without last, then goes silent.
    @(negedge clk);
    bus.req_data  = {8'h44, 8'h22, 8'h55, 8'h33};
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0000;
    bus.tx_ready  = 1'b1;
    wait_busy("to");
    chk("to_gid", 32'(grant_id), 32'd1);
    chk("to_data", 32'(bus.tx_data), 32'h55);
    @(negedge clk);
    bus.req_valid = 4'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("to_wait%0d_abort", k), 32'(abort), 32'd0);
      chk($sformatf("to_wait%0d_busy", k), 32'(busy), 32'd1);
    end
    @(negedge clk);
    bus.req_valid = 4'b0010;
    #1;
    chk("to_abort", 32'(abort), 32'd1);
    chk("to_abort_txv", 32'(bus.tx_valid), 32'd0);
    chk("to_abort_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 4'b0;
    #1;
    chk("to_pulse_end", 32'(abort), 32'd0);
    chk("to_busy_end", 32'(busy), 32'd0);
    round(4'b0110, 2'd2, "to_ptr");

    // Enable dropped during req2's message: message completes, then no new grant.
    @(negedge clk);
    bus.req_data  = {8'h44, 8'hC0, 8'h11, 8'h33};
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    bus.tx_ready  = 1'b1;
    enable        = 1'b1;
    wait_busy("en");
    chk("en_gid", 32'(grant_id), 32'd2);
    enable        = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("en_ready0", 32'(bus.req_ready), 32'b0100);
    chk("en_data0", 32'(bus.tx_data), 32'hC0);
    @(negedge clk);
    bus.req_data[23:16] = 8'hC1;
    bus.req_last        = 4'b0100;
    #1;
    chk("en_busy1", 32'(busy), 32'd1);
    chk("en_data1", 32'(bus.tx_data), 32'hC1);
    chk("en_ready1", 32'(bus.req_ready), 32'b0100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("en_hold%0d", k), 32'(busy), 32'd0);
    end
    enable = 1'b1;
    @(negedge clk); #1;
    chk("en_resume_busy", 32'(busy), 32'd1);
    chk("en_resume_gid", 32'(grant_id), 32'd3);
    bus.req_last = 4'hF;
    @(negedge clk);
    bus.req_valid = 4'b0;

    // Round-robin after a grant to requester 1: 0101 must go to 2, then 0.
    round(4'b0010, 2'd1, "pre_rr");
    round(4'b0101, 2'd2, "rr_a");
    round(4'b0001, 2'd0, "rr_b");
    round(4'b1010, 2'd1, "rr_c");

    // Asynchronous reset in the middle of a message.
    @(negedge clk);
    bus.req_data  = DATA;
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    wait_busy("mid_rst");
    resetn = 1'b0;
    #1;
    chk("mid_rst_txv", 32'(bus.tx_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    @(negedge clk);
    resetn        = 1'b1;
    bus.req_valid = 4'b0110;
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_gid", 32'(grant_id), 32'd1);
    bus.req_last = 4'hF;
    @(negedge clk);
    bus.req_valid = 4'b0;
    #1;
    chk("post_rst_done", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
